// File: rtl/hl2link_pkg.sv
// Shared codes, types and word-packing helpers for the hl2link send scheduler.
package hl2link_pkg;

    localparam int unsigned WordW = 38;

    localparam logic [1:0] TuserCmd  = 2'b01;
    localparam logic [1:0] TuserRx   = 2'b10;
    localparam logic [1:0] TuserTxiq = 2'b11;

    typedef enum logic [1:0] {
        StArb,
        StOffer,
        StBusy
    } sched_state_e;

    // Samples are MSB-aligned in the link word with zero-filled low bits.
    function automatic logic [WordW-1:0] pack_rx(input logic [23:0] d);
        return {d, 14'd0};
    endfunction

    function automatic logic [WordW-1:0] pack_txiq(input logic [31:0] d);
        return {d, 6'd0};
    endfunction

endpackage

// File: rtl/hl2link_slot.sv
// One-entry valid/ready holding buffer; emptied only when the scheduler hands its word to the link.
module hl2link_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    input  logic             clear_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    // Ready is held low during reset so no word is accepted while the block is cleared.
    assign in_ready_o = rst_n & ~full_q;
    assign load       = in_valid_i & in_ready_o;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (clear_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/hl2link_sched.sv
// Shares the hl2link send port between command, RX-sample and TX-IQ sources with a
// burst-limited command priority and round-robin between the two sample streams.
module hl2link_sched
    import hl2link_pkg::*;
#(
    parameter int unsigned CMD_BURST_MAX = 4,
    parameter int unsigned DONE_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_tvalid,
    input  logic [WordW-1:0] cmd_tdata,
    output logic             cmd_tready,
    input  logic             rx_tvalid,
    input  logic [23:0]      rx_tdata,
    output logic             rx_tready,
    input  logic             txiq_tvalid,
    input  logic [31:0]      txiq_tdata,
    output logic             txiq_tready,
    output logic             send_tvalid,
    output logic [WordW-1:0] send_tdata,
    output logic [1:0]       send_tuser,
    input  logic             send_tready,
    input  logic             send_tdone,
    input  logic             running,
    output logic             busy,
    output logic             timeout_err,
    output logic             link_abort
);

    localparam int unsigned BurstW = $clog2(CMD_BURST_MAX + 1);
    localparam int unsigned TimerW = $clog2(DONE_TIMEOUT + 1);

    logic             cmd_full, rx_full, txiq_full;
    logic             cmd_clr, rx_clr, txiq_clr;
    logic [WordW-1:0] cmd_word;
    logic [23:0]      rx_word;
    logic [31:0]      txiq_word;

    sched_state_e      state_q, state_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              rr_q, rr_d;  // 0: RX is next among samples
    logic [TimerW-1:0] timer_q, timer_d;
    logic [WordW-1:0]  tdata_q, tdata_d;
    logic [1:0]        tuser_q, tuser_d;

    logic sample_full, cmd_wins, rx_wins;

    hl2link_slot #(.WIDTH(WordW)) u_cmd_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid_i(cmd_tvalid),
        .in_data_i (cmd_tdata),
        .in_ready_o(cmd_tready),
        .clear_i   (cmd_clr),
        .full_o    (cmd_full),
        .data_o    (cmd_word)
    );

    hl2link_slot #(.WIDTH(24)) u_rx_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid_i(rx_tvalid),
        .in_data_i (rx_tdata),
        .in_ready_o(rx_tready),
        .clear_i   (rx_clr),
        .full_o    (rx_full),
        .data_o    (rx_word)
    );

    hl2link_slot #(.WIDTH(32)) u_txiq_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid_i(txiq_tvalid),
        .in_data_i (txiq_tdata),
        .in_ready_o(txiq_tready),
        .clear_i   (txiq_clr),
        .full_o    (txiq_full),
        .data_o    (txiq_word)
    );

    assign sample_full = rx_full | txiq_full;
    assign cmd_wins    = cmd_full & ~((burst_q == BurstW'(CMD_BURST_MAX)) & sample_full);
    assign rx_wins     = rx_full & (~txiq_full | ~rr_q);

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        rr_d        = rr_q;
        timer_d     = timer_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        cmd_clr     = 1'b0;
        rx_clr      = 1'b0;
        txiq_clr    = 1'b0;
        timeout_err = 1'b0;
        link_abort  = 1'b0;

        unique case (state_q)
            StArb: begin
                if (running && (cmd_full || sample_full)) begin
                    state_d = StOffer;
                    if (cmd_wins) begin
                        tdata_d = cmd_word;
                        tuser_d = TuserCmd;
                        burst_d = sample_full ? burst_q + BurstW'(1) : '0;
                    end else begin
                        tdata_d = rx_wins ? pack_rx(rx_word) : pack_txiq(txiq_word);
                        tuser_d = rx_wins ? TuserRx : TuserTxiq;
                        burst_d = '0;
                        rr_d    = ~rr_q;
                    end
                end
            end
            StOffer: begin
                // A drop before the link accepts keeps the word in its slot for a later retry.
                if (!running) begin
                    state_d = StArb;
                end else if (send_tready) begin
                    state_d = StBusy;
                    timer_d = '0;
                    unique case (tuser_q)
                        TuserCmd:  cmd_clr  = 1'b1;
                        TuserRx:   rx_clr   = 1'b1;
                        TuserTxiq: txiq_clr = 1'b1;
                        default:   ;
                    endcase
                end
            end
            StBusy: begin
                if (send_tdone) begin
                    state_d = StArb;
                end else if (!running) begin
                    link_abort = 1'b1;
                    state_d    = StArb;
                end else if (timer_q == TimerW'(DONE_TIMEOUT)) begin
                    timeout_err = 1'b1;
                    state_d     = StArb;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StArb;
            burst_q <= '0;
            rr_q    <= 1'b0;
            timer_q <= '0;
            tdata_q <= '0;
            tuser_q <= 2'b00;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            tdata_q <= tdata_d;
            tuser_q <= tuser_d;
        end
    end

    assign send_tvalid = (state_q == StOffer);
    assign send_tdata  = tdata_q;
    assign send_tuser  = tuser_q;
    assign busy        = (state_q != StArb);

endmodule

// File: tb/tb_hl2link_sched.sv
// Self-checking bench for hl2link_sched: vector table, directed corner sequences and a
// randomized run checked every cycle against a slot/queue-level reference model.
module tb_hl2link_sched;

    localparam int BURST = 4;
    localparam int TO    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_tvalid, rx_tvalid, txiq_tvalid;
    logic [37:0] cmd_tdata;
    logic [23:0] rx_tdata;
    logic [31:0] txiq_tdata;
    logic        cmd_tready, rx_tready, txiq_tready;
    logic        send_tvalid, send_tready, send_tdone, running;
    logic [37:0] send_tdata;
    logic [1:0]  send_tuser;
    logic        busy, timeout_err, link_abort;

    always #5 clk = ~clk;

    hl2link_sched #(
        .CMD_BURST_MAX(BURST),
        .DONE_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_tvalid (cmd_tvalid),
        .cmd_tdata  (cmd_tdata),
        .cmd_tready (cmd_tready),
        .rx_tvalid  (rx_tvalid),
        .rx_tdata   (rx_tdata),
        .rx_tready  (rx_tready),
        .txiq_tvalid(txiq_tvalid),
        .txiq_tdata (txiq_tdata),
        .txiq_tready(txiq_tready),
        .send_tvalid(send_tvalid),
        .send_tdata (send_tdata),
        .send_tuser (send_tuser),
        .send_tready(send_tready),
        .send_tdone (send_tdone),
        .running    (running),
        .busy       (busy),
        .timeout_err(timeout_err),
        .link_abort (link_abort)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_at = -1;
    int done_delay = 0;
    int last_xfer = -1;
    bit rnd = 1'b0;
    logic [39:0] xfers[$];

    logic        obs_tvalid, obs_busy, obs_to, obs_ab;
    logic [1:0]  obs_tuser;
    logic [37:0] obs_tdata;
    logic [2:0]  obs_rdy;
    int          obs_cyc;

    // Reference model: one entry per source (0 cmd, 1 rx, 2 txiq) and the word in flight.
    bit          m_full [3];
    logic [37:0] m_word [3];
    int          m_st;  // 0 choosing, 1 offering, 2 awaiting done
    int          m_src, m_burst, m_timer;
    bit          m_rr_txiq;
    logic [37:0] m_out;
    logic [1:0]  m_tuser;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 1'b0;
            m_word[i] = '0;
        end
        m_st = 0; m_src = 0; m_burst = 0; m_timer = 0;
        m_rr_txiq = 1'b0; m_out = '0; m_tuser = 2'b00;
    endtask

    task automatic m_step();
        bit          was [3];
        bit          vld [3];
        logic [37:0] inw [3];
        bit          samp;
        int          win;
        if (!rst_n) begin
            m_reset();
            return;
        end
        was = m_full;
        vld[0] = cmd_tvalid; vld[1] = rx_tvalid; vld[2] = txiq_tvalid;
        inw[0] = cmd_tdata; inw[1] = {rx_tdata, 14'd0}; inw[2] = {txiq_tdata, 6'd0};
        case (m_st)
            0: if (running) begin
                samp = m_full[1] || m_full[2];
                win  = -1;
                if (m_full[0] && !(m_burst == BURST && samp)) win = 0;
                else if (m_full[1] && m_full[2]) win = m_rr_txiq ? 2 : 1;
                else if (m_full[1]) win = 1;
                else if (m_full[2]) win = 2;
                if (win >= 0) begin
                    m_src   = win;
                    m_out   = m_word[win];
                    m_tuser = 2'(win + 1);
                    if (win == 0) m_burst = samp ? m_burst + 1 : 0;
                    else begin
                        m_burst   = 0;
                        m_rr_txiq = !m_rr_txiq;
                    end
                    m_st = 1;
                end
            end
            1: if (!running) m_st = 0;
               else if (send_tready) begin
                   m_full[m_src] = 1'b0;
                   m_st = 2;
                   m_timer = 0;
               end
            default: if (send_tdone || !running || m_timer == TO) m_st = 0;
                     else m_timer++;
        endcase
        for (int i = 0; i < 3; i++)
            if (!was[i] && vld[i]) begin
                m_full[i] = 1'b1;
                m_word[i] = inw[i];
            end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive stimulus, sample on the falling edge, compare with model, advance model.
    task automatic cycle();
        logic [46:0] e, a;
        bit ev;
        if (rnd) begin
            if (running) begin
                if ($urandom_range(0, 59) == 0) running = 1'b0;
            end else if ($urandom_range(0, 3) == 0) running = 1'b1;
            cmd_tvalid  = ($urandom_range(0, 3) == 0);
            rx_tvalid   = ($urandom_range(0, 2) == 0);
            txiq_tvalid = ($urandom_range(0, 2) == 0);
            cmd_tdata   = 38'({$urandom, $urandom});
            rx_tdata    = 24'($urandom);
            txiq_tdata  = $urandom;
            send_tready = running & 1'($urandom_range(0, 1));
        end
        send_tdone = (cyc == done_at);
        @(negedge clk);
        obs_tvalid = send_tvalid; obs_tuser = send_tuser; obs_tdata = send_tdata;
        obs_busy = busy; obs_to = timeout_err; obs_ab = link_abort;
        obs_rdy = {cmd_tready, rx_tready, txiq_tready};
        obs_cyc = cyc;
        ev = (m_st == 1);
        e = {ev, ev ? m_tuser : 2'b00, ev ? m_out : 38'd0, m_st != 0,
             m_st == 2 && !send_tdone && running && m_timer == TO,
             m_st == 2 && !send_tdone && !running,
             rst_n && !m_full[0], rst_n && !m_full[1], rst_n && !m_full[2]};
        a = {send_tvalid, ev ? send_tuser : 2'b00, ev ? send_tdata : 38'd0, busy,
             timeout_err, link_abort, cmd_tready, rx_tready, txiq_tready};
        chk("model", 64'(a), 64'(e));
        if (send_tvalid && send_tready) begin
            xfers.push_back({send_tuser, send_tdata});
            last_xfer = cyc;
            if (rnd) begin
                if ($urandom_range(0, 19) == 0) done_at = -1;
                else done_at = cyc + int'($urandom_range(1, 25));
            end else begin
                done_at = (done_delay > 0) ? cyc + done_delay : -1;
            end
        end
        m_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rnd = 1'b0;
        cmd_tvalid = 1'b0; rx_tvalid = 1'b0; txiq_tvalid = 1'b0;
        send_tready = 1'b0; running = 1'b1; done_at = -1; done_delay = 0;
        rst_n = 1'b0;
        m_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        xfers.delete();
    endtask

    task automatic wait_xfer(input int n, input int budget, input string name);
        for (int i = 0; i < budget && xfers.size() < n; i++) cycle();
        chk(name, 64'(xfers.size() >= n), 64'(1));
    endtask

    typedef struct {
        bit          c, r, t;
        logic [37:0] cd;
        logic [23:0] rd;
        logic [31:0] td;
        logic [1:0]  tu1;
        logic [37:0] w1;
        logic [1:0]  tu2;
    } vec_t;

    vec_t       tbl [6];
    logic [1:0] exp_seq [10];

    initial begin
        int xc, pulses, tv, tdc;

        tbl[0] = '{1, 0, 0, 38'h3A5A5A5A5A, 24'h0, 32'h0, 2'b01, 38'h3A5A5A5A5A, 2'b00};
        tbl[1] = '{0, 1, 0, 38'h0, 24'hABCDEF, 32'h0, 2'b10, {24'hABCDEF, 14'd0}, 2'b00};
        tbl[2] = '{0, 0, 1, 38'h0, 24'h0, 32'h12345678, 2'b11, {32'h12345678, 6'd0}, 2'b00};
        tbl[3] = '{0, 1, 1, 38'h0, 24'hABCDEF, 32'h12345678, 2'b10, {24'hABCDEF, 14'd0}, 2'b11};
        tbl[4] = '{1, 1, 1, 38'h0123456789, 24'h55AA33, 32'hCAFE0001, 2'b01, 38'h0123456789,
                   2'b10};
        tbl[5] = '{1, 0, 1, 38'h2000000001, 24'h0, 32'h8001_7FFE, 2'b01, 38'h2000000001,
                   2'b11};
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        // Reset values while rst_n is held low
        rst_n = 1'b0; running = 1'b1; send_tready = 1'b0; send_tdone = 1'b0;
        cmd_tvalid = 1'b0; rx_tvalid = 1'b0; txiq_tvalid = 1'b0;
        cmd_tdata = '0; rx_tdata = '0; txiq_tdata = '0;
        m_reset();
        @(posedge clk);
        #1;
        cycle();
        chk("reset_outputs", 64'({obs_tvalid, obs_tuser, obs_tdata, obs_busy, obs_to, obs_ab}),
            64'(0));
        chk("reset_ready_low", 64'(obs_rdy), 64'(0));
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", 64'(obs_rdy), 64'(3'b111));

        // Vector table: first-word latency, packing, tuser and the follow-on winner
        for (int k = 0; k < 6; k++) begin
            do_reset();
            send_tready = 1'b1;
            done_delay = 3;
            cmd_tvalid = tbl[k].c; rx_tvalid = tbl[k].r; txiq_tvalid = tbl[k].t;
            cmd_tdata = tbl[k].cd; rx_tdata = tbl[k].rd; txiq_tdata = tbl[k].td;
            cycle();
            cmd_tvalid = 1'b0; rx_tvalid = 1'b0; txiq_tvalid = 1'b0;
            cycle();
            chk($sformatf("tbl%0d_no_early_valid", k), 64'(obs_tvalid), 64'(0));
            cycle();
            chk($sformatf("tbl%0d_valid_n2", k), 64'(obs_tvalid), 64'(1));
            chk($sformatf("tbl%0d_tuser", k), 64'(obs_tuser), 64'(tbl[k].tu1));
            chk($sformatf("tbl%0d_tdata", k), 64'(obs_tdata), 64'(tbl[k].w1));
            if (tbl[k].tu2 != 2'b00) begin
                wait_xfer(2, 40, $sformatf("tbl%0d_second_xfer", k));
                if (xfers.size() >= 2)
                    chk($sformatf("tbl%0d_tuser2", k), 64'(xfers[1][39:38]), 64'(tbl[k].tu2));
            end
        end

        // Single command, done 23 cycles after the transfer
        do_reset();
        send_tready = 1'b1; done_delay = 23;
        cmd_tdata = 38'h3A5A5A5A5A; cmd_tvalid = 1'b1;
        cycle();
        cmd_tvalid = 1'b0;
        wait_xfer(1, 5, "single_cmd_xfer");
        tdc = last_xfer + 23;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (obs_cyc == tdc) chk("busy_at_done", 64'(obs_busy), 64'(1));
            if (obs_cyc == tdc + 1) begin
                chk("busy_low_after_done", 64'(obs_busy), 64'(0));
                break;
            end
        end

        // Command burst limit with RX permanently pending
        do_reset();
        send_tready = 1'b1; done_delay = 2;
        cmd_tdata = 38'h1111111111; rx_tdata = 24'h222222;
        cmd_tvalid = 1'b1; rx_tvalid = 1'b1;
        wait_xfer(10, 300, "burst_ten_xfers");
        for (int i = 0; i < 10; i++)
            if (i < xfers.size())
                chk($sformatf("burst_seq%0d", i), 64'(xfers[i][39:38]), 64'(exp_seq[i]));

        // Missing done: timeout pulse and the pending RX word offered 2 cycles later
        do_reset();
        send_tready = 1'b1; done_delay = 0;
        cmd_tdata = 38'h0ABCDE1234; rx_tdata = 24'h0F0F0F;
        cmd_tvalid = 1'b1; rx_tvalid = 1'b1;
        cycle();
        cmd_tvalid = 1'b0; rx_tvalid = 1'b0;
        wait_xfer(1, 5, "timeout_first_xfer");
        xc = last_xfer;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (obs_to) break;
        end
        chk("timeout_pulse_delay", 64'(obs_cyc - xc), 64'(65));
        cycle();
        chk("timeout_one_cycle", 64'({obs_to, obs_tvalid}), 64'(0));
        cycle();
        chk("after_timeout_offer", 64'({obs_tvalid, obs_tuser}), 64'({1'b1, 2'b10}));

        // Link drop while offering: retried later with the same word, no pulse
        do_reset();
        rx_tdata = 24'h13579B; rx_tvalid = 1'b1;
        cycle();
        rx_tvalid = 1'b0;
        cycle();
        cycle();
        chk("offer_before_drop", 64'(obs_tvalid), 64'(1));
        running = 1'b0;
        pulses = 0; tv = 0;
        cycle();
        pulses += int'(obs_to) + int'(obs_ab);
        for (int i = 0; i < 9; i++) begin
            cycle();
            pulses += int'(obs_to) + int'(obs_ab);
            tv += int'(obs_tvalid);
        end
        chk("no_offer_while_down", 64'(tv), 64'(0));
        running = 1'b1;
        cycle();
        pulses += int'(obs_to) + int'(obs_ab);
        cycle();
        chk("reoffer_same_word", 64'({obs_tvalid, obs_tuser, obs_tdata}),
            64'({1'b1, 2'b10, 24'h13579B, 14'd0}));
        chk("no_pulse_offer_drop", 64'(pulses), 64'(0));

        // Link drop while busy: abort pulse, word lost
        do_reset();
        send_tready = 1'b1; done_delay = 0;
        txiq_tdata = 32'hDEAD_BEEF; txiq_tvalid = 1'b1;
        cycle();
        txiq_tvalid = 1'b0;
        wait_xfer(1, 5, "abort_xfer");
        cycle();
        cycle();
        running = 1'b0;
        cycle();
        chk("link_abort_pulse", 64'({obs_ab, obs_busy}), 64'(2'b11));
        cycle();
        chk("abort_clears_busy", 64'({obs_ab, obs_busy}), 64'(0));
        running = 1'b1;
        tv = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tv += int'(obs_tvalid);
        end
        chk("aborted_word_lost", 64'(tv), 64'(0));

        // Reset asserted in BUSY with every slot full
        do_reset();
        send_tready = 1'b1; done_delay = 0;
        cmd_tvalid = 1'b1; rx_tvalid = 1'b1; txiq_tvalid = 1'b1;
        wait_xfer(1, 6, "rst_mid_xfer");
        cycle();
        cycle();
        chk("busy_all_full", 64'({obs_busy, obs_rdy}), 64'(4'b1000));
        cmd_tvalid = 1'b0; rx_tvalid = 1'b0; txiq_tvalid = 1'b0;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("reset_immediate", 64'({send_tvalid, send_tuser, send_tdata, busy, timeout_err,
                                    link_abort, cmd_tready, rx_tready, txiq_tready}), 64'(0));
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("slots_empty_after_reset", 64'(obs_rdy), 64'(3'b111));
        tv = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tv += int'(obs_tvalid);
        end
        chk("no_stale_offer", 64'(tv), 64'(0));

        // Randomized traffic against the model
        do_reset();
        rnd = 1'b1;
        for (int i = 0; i < 4000; i++) cycle();
        rnd = 1'b0;
        chk("random_traffic_flowed", 64'(xfers.size() > 50), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/hl2link_sched.md
# hl2link_sched

Scheduler that shares the `hl2link` send interface between three word sources:
- command words (tuser 01, 38 bits)
- RX samples (tuser 10, 24 bits)
- TX IQ samples (tuser 11, 16+16 bits)

Each source feeds a one-entry slot. A fairness-controlled arbiter chooses the next word, offers it on the `send_*` handshake, and tracks the word until `send_tdone`. A missing `send_tdone` and a link drop (`running` low) are both handled here, never by the sources.

## Interface
- CMD_BURST_MAX, 4: max consecutive command grants while any sample slot is full.
- DONE_TIMEOUT, 64: cycles allowed in BUSY before `timeout_err`.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_tvalid / cmd_tdata / cmd_tready  in/in/out  1/38/1  command source.
- rx_tvalid / rx_tdata / rx_tready  in/in/out  1/24/1  RX sample source.
- txiq_tvalid / txiq_tdata / txiq_tready  in/in/out  1/32/1  TX IQ source; I in [31:16], Q in [15:0].
- send_tvalid  out  1  word offered to `hl2link`.
- send_tdata  out  38  MSB-aligned word.
- send_tuser  out  2  word type 01/10/11; never 00 while `send_tvalid`=1.
- send_tready  in  1  link accepts.
- send_tdone  in  1  link finished word.
- running  in  1  link trained.
- busy  out  1  state ≠ ARB.
- timeout_err  out  1  one-cycle pulse.
- link_abort  out  1  one-cycle pulse.

## Operation
- Slots: src_tready = ~slot_full. A slot loads on src_tvalid & src_tready. It clears only on the link transfer of that slot. Load and drain of the same slot never occur in one cycle.
- Packing (zero-fill low bits):
  - cmd → [37:0].
  - rx → [37:14].
  - txiq → [37:6].
- Grant rule, evaluated in ARB when `running`=1 and any slot is full:
  - Command wins unless `burst_cnt` == CMD_BURST_MAX and a sample slot is full.
  - Among samples, `rr_ptr` picks RX or TXIQ. If only one is full, it wins.
  - `rr_ptr` toggles after every sample grant.
  - `burst_cnt` increments on each command grant while a sample slot is full. It clears on a sample grant or on a command grant with no sample pending.
- States:
  - ARB: grant found → register sel/tdata/tuser, go OFFER.
  - OFFER: `send_tvalid`=1. Data and tuser are held stable and never re-arbitrated. On `send_tready` (transfer): clear the slot, go BUSY. If `running` falls: go ARB, slot kept, no pulse.
  - BUSY: on `send_tdone` → ARB. If the timer reaches DONE_TIMEOUT → pulse `timeout_err`, go ARB. If `running` falls → pulse `link_abort`, go ARB; the word is lost.
  - Priority in BUSY when events coincide: `send_tdone` over `running` low over timeout.
- Reset values:
  - state ARB; all slots empty; `burst_cnt` 0; `rr_ptr` → RX first.
  - `send_tvalid` 0, `send_tdata` 0, `send_tuser` 00.
  - `busy`, `timeout_err`, `link_abort` 0.
  - src_tready 0 while `rst_n` is low.
- Reset mid-operation: all slot contents are discarded.

## Timing
- All `send_*` outputs are registered.
- Source handshake at cycle N → slot full at N+1 → ARB decision at N+1 → `send_tvalid` at N+2.
- If `send_tready` is high at N+2, the transfer happens at N+2 and BUSY starts at N+3.
- After `send_tdone` at cycle M: ARB at M+1, next offer at M+2. This matches `hl2link` returning to idle at M+1.
- BUSY timer starts at 0 on BUSY entry. `timeout_err` fires in the cycle the count equals DONE_TIMEOUT.
- `running` is sampled every cycle. A drop in ARB only stops new offers.

## Structure
- `hl2link_pkg` holds:
  - tuser codes CMD=01, RX=10, TXIQ=11.
  - the 38-bit word width.
  - sched state enum ARB/OFFER/BUSY.
  - packing functions for rx and txiq.
- Sub-module `hl2link_slot` (parameter WIDTH): a one-entry valid/ready buffer, instantiated three times.
- The arbiter, FSM and timers live in the top module.

## Test plan
- Single command 0x3A_5A5A_5A5A, `send_tready`=1, `send_tdone` 23 cycles later: `send_tdata`=0x3A5A5A5A5A, tuser 01, `send_tvalid` 2 cycles after the source handshake, `busy` low 1 cycle after done.
- RX 0xABCDEF and TXIQ I=0x1234, Q=0x5678 loaded together, no cmd: RX first with tdata 0xABCDEF<<14; then TXIQ with tdata 0x12345678<<6.
- Command source always full, RX full, CMD_BURST_MAX=4: grant sequence C,C,C,C,R,C,C,C,C,R.
- No `send_tdone` after transfer: `timeout_err` pulses exactly 64 cycles after BUSY entry; the next pending word is offered 2 cycles later.
- `running` dropped during OFFER, restored 10 cycles later: same word re-offered, no pulse.
- `running` dropped during BUSY: `link_abort` pulses and the word is lost.
- `rst_n` asserted in BUSY with all slots full: outputs at reset values immediately; after release the slots are empty and all readies are 1.
